// File: rtl/orbit_position_engine_if.sv
// Bundle between the tick/frame timing source, the orbit position engine and
// the planet renderer.
// Handshake: tick_* and frame_start are single-cycle pulses sampled on every
// rising clock edge (no ready); the engine answers a frame_start seen while
// idle with a single-cycle pos_valid pulse, in the same cycle the six
// coordinates change. busy is high while a frame update is in flight; a
// frame_start that arrives while busy is dropped.
// dbg_state mirrors the engine FSM state for debug and checkers.
interface orbit_position_engine_if #(
    parameter int COORD_W = 12
);
    logic               tick_mercur;
    logic               tick_venus;
    logic               tick_earth;
    logic               frame_start;
    logic [COORD_W-1:0] mercur_x;
    logic [COORD_W-1:0] mercur_y;
    logic [COORD_W-1:0] venus_x;
    logic [COORD_W-1:0] venus_y;
    logic [COORD_W-1:0] earth_x;
    logic [COORD_W-1:0] earth_y;
    logic               pos_valid;
    logic               busy;
    logic [2:0]         dbg_state;

    modport master (
        output tick_mercur, tick_venus, tick_earth, frame_start,
        input  mercur_x, mercur_y, venus_x, venus_y, earth_x, earth_y,
        input  pos_valid, busy, dbg_state
    );

    modport slave (
        input  tick_mercur, tick_venus, tick_earth, frame_start,
        output mercur_x, mercur_y, venus_x, venus_y, earth_x, earth_y,
        output pos_valid, busy, dbg_state
    );
endinterface

// File: rtl/orbit_position_engine.sv
// Orbit position engine: keeps one orbit phase per planet and, once per video
// frame, turns the three phases into screen coordinates through one shared
// sine ROM, then publishes all three positions in a single edge.
// Optional feature macro: ORBIT_PAUSE_EN adds a `pause` input that freezes
// the phases (frame updates keep running).
module orbit_position_engine #(
    parameter int ANGLE_W  = 8,
    parameter int COORD_W  = 12,
    parameter int CX       = 960,
    parameter int CY       = 540,
    parameter int R_MERCUR = 120,
    parameter int R_VENUS  = 220,
    parameter int R_EARTH  = 320
) (
    input  logic clk1485,
    input  logic rst_n,
`ifdef ORBIT_PAUSE_EN
    input  logic pause,
`endif
    orbit_position_engine_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_COS = 3'd1;
    localparam logic [2:0] S_RD_SIN = 3'd2;
    localparam logic [2:0] S_CALC   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64; the other
    // three quadrants come from mirroring the index and negating.
    localparam int QTAB [0:64] = '{
          0,   3,   6,   9,  12,  16,  19,  22,  25,  28,  31,  34,  37,
         40,  43,  46,  49,  51,  54,  57,  60,  63,  65,  68,  71,  73,
         76,  78,  81,  83,  85,  88,  90,  92,  94,  96,  98, 100, 102,
        104, 106, 107, 109, 111, 112, 113, 115, 116, 117, 118, 120, 121,
        122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127, 127
    };

    logic [2:0]         r_state;
    logic [1:0]         r_p;
    logic [ANGLE_W-1:0] r_phase [0:2];
    logic [ANGLE_W-1:0] r_snap  [0:2];
    logic signed [7:0]  r_rom_q;
    logic signed [7:0]  r_cos;
    logic [COORD_W-1:0] r_sh_x  [0:2];
    logic [COORD_W-1:0] r_sh_y  [0:2];
    logic [COORD_W-1:0] r_out_x [0:2];
    logic [COORD_W-1:0] r_out_y [0:2];
    logic               r_pos_valid;

    logic [2:0]          w_tick;
    logic [ANGLE_W-1:0]  w_addr;
    logic [6:0]          w_qidx;
    logic [6:0]          w_mag;
    logic signed [7:0]   w_sin;
    logic signed [16:0]  w_rad;
    logic signed [16:0]  w_cos_ext;
    logic signed [16:0]  w_sin_ext;
    logic signed [16:0]  w_prod_x;
    logic signed [16:0]  w_prod_y;
    logic signed [16:0]  w_dx;
    logic signed [16:0]  w_dy;
    logic [COORD_W-1:0]  w_x;
    logic [COORD_W-1:0]  w_y;

`ifdef ORBIT_PAUSE_EN
    assign w_tick = {bus.tick_earth, bus.tick_venus, bus.tick_mercur} & {3{~pause}};
`else
    assign w_tick = {bus.tick_earth, bus.tick_venus, bus.tick_mercur};
`endif

    // Phase accumulators: every accepted tick advances its planet, busy or not.
    always_ff @(posedge clk1485 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) r_phase[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (w_tick[i]) r_phase[i] <= r_phase[i] + 1'b1;
        end
    end

    // Sine ROM address and quarter-wave decode; cos(i) is read as sin(i+64).
    always_comb begin
        w_addr = r_snap[r_p];
        if (r_state == S_RD_COS) w_addr = r_snap[r_p] + ANGLE_W'(64);
        w_qidx = w_addr[6] ? 7'd64 - {1'b0, w_addr[5:0]} : {1'b0, w_addr[5:0]};
        w_mag  = 7'(QTAB[w_qidx]);
        w_sin  = w_addr[7] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
    end

    // One-cycle registered ROM read.
    always_ff @(posedge clk1485 or negedge rst_n) begin
        if (!rst_n) r_rom_q <= '0;
        else        r_rom_q <= w_sin;
    end

    // Scale cos/sin by the current planet radius; arithmetic shift floors.
    always_comb begin
        case (r_p)
            2'd0:    w_rad = 17'(R_MERCUR);
            2'd1:    w_rad = 17'(R_VENUS);
            default: w_rad = 17'(R_EARTH);
        endcase
        w_cos_ext = {{9{r_cos[7]}}, r_cos};
        w_sin_ext = {{9{r_rom_q[7]}}, r_rom_q};
        w_prod_x  = w_rad * w_cos_ext;
        w_prod_y  = w_rad * w_sin_ext;
        w_dx      = w_prod_x >>> 7;
        w_dy      = w_prod_y >>> 7;
        w_x       = COORD_W'(CX) + COORD_W'(w_dx);
        w_y       = COORD_W'(CY) + COORD_W'(w_dy);
    end

    // Frame FSM: snapshot, three read/read/calc passes, then atomic commit.
    always_ff @(posedge clk1485 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_cos       <= '0;
            r_pos_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_snap[i]  <= '0;
                r_sh_x[i]  <= COORD_W'(CX);
                r_sh_y[i]  <= COORD_W'(CY);
                r_out_x[i] <= COORD_W'(CX);
                r_out_y[i] <= COORD_W'(CY);
            end
        end else begin
            r_pos_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        for (int i = 0; i < 3; i++) r_snap[i] <= r_phase[i];
                        r_p     <= '0;
                        r_state <= S_RD_COS;
                    end
                end
                S_RD_COS: r_state <= S_RD_SIN;
                S_RD_SIN: begin
                    r_cos   <= r_rom_q;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_sh_x[r_p] <= w_x;
                    r_sh_y[r_p] <= w_y;
                    if (r_p == 2'd2) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_p     <= r_p + 2'd1;
                        r_state <= S_RD_COS;
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < 3; i++) begin
                        r_out_x[i] <= r_sh_x[i];
                        r_out_y[i] <= r_sh_y[i];
                    end
                    r_pos_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mercur_x  = r_out_x[0];
    assign bus.mercur_y  = r_out_y[0];
    assign bus.venus_x   = r_out_x[1];
    assign bus.venus_y   = r_out_y[1];
    assign bus.earth_x   = r_out_x[2];
    assign bus.earth_y   = r_out_y[2];
    assign bus.pos_valid = r_pos_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_orbit_position_engine.sv
// Bench for orbit_position_engine: directed scenarios plus random ticks and
// frames, checked by a scoreboard against a trigonometric reference model.
module tb_orbit_position_engine;
    localparam int CW = 12;
    localparam int CXV = 960;
    localparam int CYV = 540;
    localparam int RAD [0:2] = '{120, 220, 320};

    logic clk1485 = 1'b0;
    logic rst_n   = 1'b0;
`ifdef ORBIT_PAUSE_EN
    logic pause   = 1'b0;
`endif

    orbit_position_engine_if #(.COORD_W(CW)) bus ();

    orbit_position_engine dut (
        .clk1485 (clk1485),
        .rst_n   (rst_n),
`ifdef ORBIT_PAUSE_EN
        .pause   (pause),
`endif
        .bus     (bus)
    );

    // Clock and cycle counter
    always #5 clk1485 = ~clk1485;
    int cyc = 0;
    always @(posedge clk1485) cyc <= cyc + 1;

    // Scoreboard state
    logic [6*CW-1:0] exp_q[$];
    int              exp_cyc_q[$];
    logic [6*CW-1:0] cur;
    int              ph [0:2];
    int              last_edge = -100;
    int              errors = 0;
    int              checks = 0;

    // Reference model: round(127*sin) and floor scaling in real arithmetic
    function automatic int lut(input int i);
        real v;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
        if (v >= 0.0) return $rtoi($floor(v + 0.5));
        return -$rtoi($floor(-v + 0.5));
    endfunction

    function automatic logic [CW-1:0] coord(input int c, input int r, input int s);
        return CW'(c + $rtoi($floor(real'(r * s) / 128.0)));
    endfunction

    function automatic logic [6*CW-1:0] model_pos(input int p0, input int p1, input int p2);
        int p [0:2];
        logic [6*CW-1:0] res;
        p[0] = p0; p[1] = p1; p[2] = p2;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            res = {res[4*CW-1:0],
                   coord(CXV, RAD[k], lut((p[k] + 64) % 256)),
                   coord(CYV, RAD[k], lut(p[k]))};
        end
        return res;
    endfunction

    function automatic logic [6*CW-1:0] reset_pos();
        return {3{CW'(CXV), CW'(CYV)}};
    endfunction

    task automatic chk(input string nm, input logic [6*CW-1:0] act, input logic [6*CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Driver: one clock of stimulus, then advance the model
    task automatic step(input bit f, input bit m, input bit v, input bit e);
        int ed;
        bus.frame_start = f;
        bus.tick_mercur = m;
        bus.tick_venus  = v;
        bus.tick_earth  = e;
        @(negedge clk1485);
        bus.frame_start = 1'b0;
        bus.tick_mercur = 1'b0;
        bus.tick_venus  = 1'b0;
        bus.tick_earth  = 1'b0;
        ed = cyc;
        if (f && (ed - last_edge >= 11)) begin
            exp_q.push_back(model_pos(ph[0], ph[1], ph[2]));
            exp_cyc_q.push_back(ed + 10);
            last_edge = ed;
        end
        if (m) ph[0] = (ph[0] + 1) % 256;
        if (v) ph[1] = (ph[1] + 1) % 256;
        if (e) ph[2] = (ph[2] + 1) % 256;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [6*CW-1:0] dut_pos();
        return {bus.mercur_x, bus.mercur_y, bus.venus_x, bus.venus_y, bus.earth_x, bus.earth_y};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_pos", dut_pos(), reset_pos());
        chk("reset_busy", {71'd0, bus.busy}, '0);
        chk("reset_valid", {71'd0, bus.pos_valid}, '0);
        exp_q.delete();
        exp_cyc_q.delete();
        for (int i = 0; i < 3; i++) ph[i] = 0;
        last_edge = -100;
        cur = reset_pos();
        @(negedge clk1485);
        @(negedge clk1485);
        rst_n = 1'b1;
    endtask

    // Monitor: busy, hold, and pop/compare on every pos_valid
    initial begin
        forever begin
            @(negedge clk1485);
            #1;
            if (!rst_n) continue;
            chk("busy", {71'd0, bus.busy},
                {71'd0, (cyc >= last_edge && cyc <= last_edge + 9)});
            if (bus.pos_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pos_valid_unexpected at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    logic [6*CW-1:0] e;
                    int ec;
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("positions", dut_pos(), e);
                    chk("latency", 72'(cyc), 72'(ec));
                    cur = e;
                end
            end else begin
                if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                    checks++;
                    errors++;
                    $display("FAIL pos_valid_timeout at cycle %0d: got 0 expected pulse at %0d",
                             cyc, exp_cyc_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
                chk("hold", dut_pos(), cur);
            end
        end
    end

    // Stimulus sequence
    initial begin
        bus.frame_start = 1'b0;
        bus.tick_mercur = 1'b0;
        bus.tick_venus  = 1'b0;
        bus.tick_earth  = 1'b0;
        cur = reset_pos();
        @(negedge clk1485);
        apply_reset();

        // First frame from reset phases
        step(1'b1, 1'b0, 1'b0, 1'b0); idle(12);
        // Quarter orbit of Mercury, then half orbit (negative floor)
        repeat (64) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0); idle(12);
        repeat (64) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0); idle(12);
        // Earth phase wraps back to zero
        repeat (256) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0); idle(12);
        // Second frame_start while busy is dropped
        step(1'b1, 1'b0, 1'b1, 1'b0); idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0); idle(12);
        // Tick coincident with snapshot
        step(1'b1, 1'b1, 1'b1, 1'b1); idle(12);
        step(1'b1, 1'b0, 1'b0, 1'b0); idle(12);
        // Reset in the middle of a frame update
        step(1'b1, 1'b0, 1'b0, 1'b0); idle(4);
        apply_reset();
        idle(2);
        // Random ticks and frames
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        idle(15);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending frames expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
